// File: rtl/lap_stopwatch.sv
// lap_stopwatch: start/pause/clear stopwatch with a prescaled seconds/minutes chain.
// Define LAP_STOPWATCH_LAP_EN to build the lap-capture FIFO; otherwise all lap outputs read 0.
module lap_stopwatch #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned MIN_WIDTH     = 8,
  parameter int unsigned LAP_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  input  logic                         lap,
  input  logic                         lap_rd,
  output logic [MIN_WIDTH-1:0]         minute,
  output logic [5:0]                   seconds,
  output logic [1:0]                   state,
  output logic                         lap_valid,
  output logic [MIN_WIDTH-1:0]         lap_minute,
  output logic [5:0]                   lap_seconds,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_overflow
);

  localparam int unsigned PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned PTR_W = $clog2(LAP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAP_W = MIN_WIDTH + 6;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_e;

  state_e                 state_q, state_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [5:0]             sec_q, sec_d;
  logic [MIN_WIDTH-1:0]   min_q, min_d;

  // Control FSM and counter chain; a stop on a tick edge suppresses the tick.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sec_d   = sec_q;
    min_d   = min_q;
    if (clear) begin
      state_d = ST_IDLE;
      pre_d   = '0;
      sec_d   = '0;
      min_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (start) state_d = ST_RUN;
        ST_RUN:   if (stop) state_d = ST_PAUSE;
        ST_PAUSE: if (start && !stop) state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
      if (state_q == ST_RUN && !stop) begin
        if (pre_q == PRE_MAX) begin
          pre_d = '0;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            min_d = min_q + MIN_WIDTH'(1);
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
    end
  end

  assign minute  = min_q;
  assign seconds = sec_q;
  assign state   = state_q;

`ifdef LAP_STOPWATCH_LAP_EN
  logic [LAP_W-1:0]  mem_q [LAP_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, remain;
  logic [LAP_W-1:0]  head_q, head_d, cur;
  logic              ovf_q, ovf_d, valid_q, valid_d;
  logic              push_req, push, pop, full;

  // Push/pop arbitration; a full FIFO still accepts a push if a pop frees a slot.
  always_comb begin
    cur      = {min_q, sec_q};
    push_req = lap && (state_q != ST_IDLE) && !clear;
    pop      = lap_rd && (cnt_q != '0) && !clear;
    full     = (cnt_q == CNT_W'(LAP_DEPTH));
    push     = push_req && (!full || pop);
    remain   = cnt_q - CNT_W'(pop);
    cnt_d    = remain + CNT_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    ovf_d    = ovf_q | (push_req && full && !pop);
    head_d   = head_q;
    if (remain != '0) begin
      head_d = mem_q[rd_ptr_d];
    end else if (push) begin
      head_d = cur;
    end
    if (clear) begin
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      ovf_d    = 1'b0;
    end
    valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cur;
  end

  assign lap_valid    = valid_q;
  assign lap_count    = cnt_q;
  assign lap_overflow = ovf_q;
  assign lap_minute   = head_q[LAP_W-1:6];
  assign lap_seconds  = head_q[5:0];
`else
  logic unused_lap;
  assign unused_lap   = ^{lap, lap_rd};
  assign lap_valid    = 1'b0;
  assign lap_count    = '0;
  assign lap_overflow = 1'b0;
  assign lap_minute   = '0;
  assign lap_seconds  = '0;
`endif

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: two instances (4 ticks/s and 1 tick/s with 2-bit minutes)
// driven by shared stimulus and compared against an elapsed-seconds reference model.
module tb_lap_stopwatch;

  localparam int unsigned TPS_A = 4;
  localparam int unsigned MW_A  = 8;
  localparam int unsigned TPS_B = 1;
  localparam int unsigned MW_B  = 2;
  localparam int unsigned DEPTH = 4;
`ifdef LAP_STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0, lap_rd = 1'b0;

  logic [MW_A-1:0] a_minute, a_lap_minute;
  logic [5:0]      a_seconds, a_lap_seconds;
  logic [1:0]      a_state;
  logic            a_lap_valid, a_lap_overflow;
  logic [2:0]      a_lap_count;
  logic [MW_B-1:0] b_minute, b_lap_minute;
  logic [5:0]      b_seconds, b_lap_seconds;
  logic [1:0]      b_state;
  logic            b_lap_valid, b_lap_overflow;
  logic [2:0]      b_lap_count;

  lap_stopwatch #(.TICKS_PER_SEC(TPS_A), .MIN_WIDTH(MW_A), .LAP_DEPTH(DEPTH)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .lap_rd(lap_rd), .minute(a_minute), .seconds(a_seconds), .state(a_state),
    .lap_valid(a_lap_valid), .lap_minute(a_lap_minute), .lap_seconds(a_lap_seconds),
    .lap_count(a_lap_count), .lap_overflow(a_lap_overflow));

  lap_stopwatch #(.TICKS_PER_SEC(TPS_B), .MIN_WIDTH(MW_B), .LAP_DEPTH(DEPTH)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .lap_rd(lap_rd), .minute(b_minute), .seconds(b_seconds), .state(b_state),
    .lap_valid(b_lap_valid), .lap_minute(b_lap_minute), .lap_seconds(b_lap_seconds),
    .lap_count(b_lap_count), .lap_overflow(b_lap_overflow));

  always #5 clk = ~clk;

  // Reference model: time is kept as total elapsed seconds; laps are snapshots of it.
  typedef struct {
    int st;
    int pre;
    int total;
    int head;
    bit ovf;
  } mdl_t;

  mdl_t ma, mb;
  int   qa[$];
  int   qb[$];
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    bit s, p, c, l, r;
    int est, esec, emin;
  } vec_t;
  vec_t tbl[21];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic mreset(inout mdl_t m, inout int q[$]);
    m.st = 0; m.pre = 0; m.total = 0; m.head = 0; m.ovf = 1'b0;
    q.delete();
  endtask

  task automatic mstep(input int tps, inout mdl_t m, inout int q[$],
                       input bit s, input bit p, input bit c, input bit l, input bit r);
    int old_st;
    int old_total;
    bit do_pop, do_push;
    old_st = m.st;
    old_total = m.total;
    if (c) begin
      m.st = 0; m.pre = 0; m.total = 0; m.ovf = 1'b0;
      q.delete();
    end else begin
      do_pop  = r && (q.size() > 0);
      do_push = l && (old_st != 0);
      if (do_push && q.size() == DEPTH && !do_pop) begin
        m.ovf = 1'b1;
      end else begin
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(old_total);
      end
      if (q.size() > 0) m.head = q[0];
      if (old_st == 1 && !p) begin
        m.pre++;
        if (m.pre == tps) begin
          m.pre = 0;
          m.total++;
        end
      end
      if (old_st == 0 && s) m.st = 1;
      else if (old_st == 1 && p) m.st = 2;
      else if (old_st == 2 && s && !p) m.st = 1;
    end
  endtask

  task automatic check_dut(input string tag, input int mw, input mdl_t m, input int qsize,
                           input int st, input int mn, input int sc, input int lv,
                           input int lc, input int lo, input int lm, input int ls);
    int modv;
    modv = 1 << mw;
    chk({tag, "_state"}, st, m.st);
    chk({tag, "_minute"}, mn, (m.total / 60) % modv);
    chk({tag, "_seconds"}, sc, m.total % 60);
    chk({tag, "_lap_valid"}, lv, LAP_EN ? int'(qsize > 0) : 0);
    chk({tag, "_lap_count"}, lc, LAP_EN ? qsize : 0);
    chk({tag, "_lap_overflow"}, lo, LAP_EN ? int'(m.ovf) : 0);
    chk({tag, "_lap_minute"}, lm, LAP_EN ? (m.head / 60) % modv : 0);
    chk({tag, "_lap_seconds"}, ls, LAP_EN ? m.head % 60 : 0);
  endtask

  task automatic check_all();
    check_dut("a", MW_A, ma, qa.size(), int'(a_state), int'(a_minute), int'(a_seconds),
              int'(a_lap_valid), int'(a_lap_count), int'(a_lap_overflow),
              int'(a_lap_minute), int'(a_lap_seconds));
    check_dut("b", MW_B, mb, qb.size(), int'(b_state), int'(b_minute), int'(b_seconds),
              int'(b_lap_valid), int'(b_lap_count), int'(b_lap_overflow),
              int'(b_lap_minute), int'(b_lap_seconds));
  endtask

  // One clock: drive inputs, advance both models at the edge, check 1 time unit later.
  task automatic cyc(input bit s, input bit p, input bit c, input bit l, input bit r);
    start = s; stop = p; clear = c; lap = l; lap_rd = r;
    @(posedge clk);
    mstep(TPS_A, ma, qa, s, p, c, l, r);
    mstep(TPS_B, mb, qb, s, p, c, l, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1,0,0,0,0, 1,0,0};
    tbl[1]  = '{0,0,0,0,0, 1,0,0};
    tbl[2]  = '{0,0,0,0,0, 1,0,0};
    tbl[3]  = '{0,0,0,0,0, 1,0,0};
    tbl[4]  = '{0,0,0,0,0, 1,1,0};
    tbl[5]  = '{0,0,0,0,0, 1,1,0};
    tbl[6]  = '{0,0,0,0,0, 1,1,0};
    tbl[7]  = '{0,0,0,0,0, 1,1,0};
    tbl[8]  = '{0,0,0,0,0, 1,2,0};
    tbl[9]  = '{0,1,0,0,0, 2,2,0};
    tbl[10] = '{0,0,0,0,0, 2,2,0};
    tbl[11] = '{1,1,0,0,0, 2,2,0};
    tbl[12] = '{1,0,0,0,0, 1,2,0};
    tbl[13] = '{0,0,0,0,0, 1,2,0};
    tbl[14] = '{0,0,0,0,0, 1,2,0};
    tbl[15] = '{0,0,0,0,0, 1,2,0};
    tbl[16] = '{0,0,0,0,0, 1,3,0};
    tbl[17] = '{1,1,1,0,0, 0,0,0};
    tbl[18] = '{1,1,0,0,0, 1,0,0};
    tbl[19] = '{1,1,0,0,0, 2,0,0};
    tbl[20] = '{0,0,1,0,0, 0,0,0};

    mreset(ma, qa);
    mreset(mb, qb);
    #2 reset = 1'b0;
    #2 check_all();
    #4 reset = 1'b1;

    // Basic run, pause and control-priority table on the 4-tick instance.
    for (int i = 0; i < 21; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l, tbl[i].r);
      chk($sformatf("tbl%0d_state", i), int'(a_state), tbl[i].est);
      chk($sformatf("tbl%0d_seconds", i), int'(a_seconds), tbl[i].esec);
      chk($sformatf("tbl%0d_minute", i), int'(a_minute), tbl[i].emin);
    end

    // Pause mid-second and resume: partial second is preserved.
    cyc(1, 0, 0, 0, 0);
    idle(2);
    cyc(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("pause_hold_state", int'(a_state), 2);
      chk("pause_hold_seconds", int'(a_seconds), 0);
    end
    cyc(1, 0, 0, 0, 0);
    idle(1);
    chk("resume_1cyc_seconds", int'(a_seconds), 0);
    idle(1);
    chk("resume_2cyc_seconds", int'(a_seconds), 1);

    // Rollover on the 1-tick, 2-bit-minute instance.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    idle(60);
    chk("roll60_b_seconds", int'(b_seconds), 0);
    chk("roll60_b_minute", int'(b_minute), 1);
    idle(180);
    chk("roll240_b_seconds", int'(b_seconds), 0);
    chk("roll240_b_minute", int'(b_minute), 0);

    // Lap FIFO: overflow, push+pop when full, drain, clear.
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      idle(5);
      cyc(0, 0, 0, 1, 0);
    end
    chk("lap5_count", int'(a_lap_count), LAP_EN ? 4 : 0);
    chk("lap5_overflow", int'(a_lap_overflow), LAP_EN ? 1 : 0);
    cyc(0, 0, 0, 1, 1);
    chk("lap_full_pushpop_count", int'(a_lap_count), LAP_EN ? 4 : 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 1);
    chk("lap_drained_valid", int'(a_lap_valid), 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 1, 1, 0);
    chk("lap_clear_overflow", int'(a_lap_overflow), 0);
    chk("lap_clear_valid", int'(a_lap_valid), 0);

    // Asynchronous reset between edges at 3 minutes with two laps stored.
    cyc(1, 0, 0, 0, 0);
    idle(720);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    chk("pre_reset_minute", int'(a_minute), 3);
    chk("pre_reset_count", int'(a_lap_count), LAP_EN ? 2 : 0);
    #2 reset = 1'b0;
    mreset(ma, qa);
    mreset(mb, qb);
    #1;
    chk("async_rst_minute", int'(a_minute), 0);
    chk("async_rst_state", int'(a_state), 0);
    chk("async_rst_count", int'(a_lap_count), 0);
    check_all();
    #2 reset = 1'b1;

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(127) == 0,
          $urandom_range(3) == 0, $urandom_range(3) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lap_stopwatch.md
# lap_stopwatch

Parametrised second-generation stopwatch: start/stop/clear control FSM, a clock prescaler producing one-second ticks, and a seconds/minutes counter chain of configurable width. It adds pause/resume and a lap-capture FIFO that records split times for a downstream reader. It sits where the first-generation stopwatch top sat, driving the same minute/seconds/state display outputs.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: `clk` cycles per counted second; must be ≥1.
- `MIN_WIDTH`, default 8: width of the minutes counter.
- `LAP_DEPTH`, default 4: lap FIFO entries; must be a power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: start/resume request, level-sampled each edge.
- `stop` in 1: pause request.
- `clear` in 1: return to IDLE, zero counters, flush FIFO.
- `lap` in 1: capture the current time into the FIFO.
- `lap_rd` in 1: pop the FIFO head; ignored when `lap_valid`=0.
- `minute` out MIN_WIDTH: minutes count.
- `seconds` out 6: seconds count, 0–59.
- `state` out 2: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10.
- `lap_valid` out 1: FIFO non-empty.
- `lap_minute` out MIN_WIDTH: head entry minutes (first-word-fall-through).
- `lap_seconds` out 6: head entry seconds.
- `lap_count` out $clog2(LAP_DEPTH)+1: number of stored entries.
- `lap_overflow` out 1: sticky flag, set when a lap is dropped because the FIFO is full.

## Operation
- Reset (`reset`=0, any time, asynchronous): state IDLE, prescaler 0, `minute`=0, `seconds`=0, FIFO empty, `lap_valid`=0, `lap_count`=0, `lap_overflow`=0, `lap_minute`=0, `lap_seconds`=0.
- Control priority per edge: `clear` > `stop` > `start`.
- `clear` from any state goes to IDLE. It zeroes the prescaler, `minute` and `seconds`, empties the FIFO and clears `lap_overflow`. A `lap` or `lap_rd` in the same cycle is ignored.
- IDLE + `start` → RUNNING.
- RUNNING + `stop` → PAUSED.
- PAUSED + `start` → RUNNING. Counts are kept.
- RUNNING + `start` and PAUSED + `stop` are no-ops.
- Prescaler counts only in RUNNING. It is held in PAUSED, so resume continues the partial second, and it is zeroed in IDLE.
- Second tick: fires when the prescaler is at TICKS_PER_SEC−1 in RUNNING. The prescaler then returns to 0.
- On a tick, `seconds` increments. At 59 it wraps to 0 and `minute` increments.
- `minute` wraps from 2^MIN_WIDTH−1 to 0 modulo its width. No flag is raised.
- If `stop` is asserted on a tick edge, the state becomes PAUSED and the tick is suppressed (the stop has priority). The prescaler holds at TICKS_PER_SEC−1.
- Lap push: `lap`=1 in RUNNING or PAUSED pushes {`minute`,`seconds`} as registered before that edge's update. In IDLE, `lap` is ignored.
- Full FIFO, push without pop: the entry is dropped and `lap_overflow` is set.
- Full FIFO, push with pop in the same cycle: both succeed and `lap_count` is unchanged.
- Empty FIFO with `lap_rd`: no effect.
- Head outputs hold their last value when the FIFO is empty.

## Timing
- Control: `start` sampled at edge N gives `state`=RUNNING after edge N.
- First second: with no pause, `seconds`=1 after edge N+TICKS_PER_SEC.
- Counters are registered outputs with no combinational path from inputs to `minute`, `seconds` or `state`.
- Lap latency: `lap` at edge M gives `lap_valid`=1 and head outputs valid after edge M, when the FIFO was empty.
- Pop: `lap_rd` at edge P advances the head after edge P.
- `lap_count` updates on the same edge as a push or pop.

## Configuration
- `LAP_STOPWATCH_LAP_EN` defined: the lap FIFO is built as described above.
- `LAP_STOPWATCH_LAP_EN` undefined: no FIFO storage is built and `lap`/`lap_rd` are ignored. `lap_valid`, `lap_count`, `lap_overflow`, `lap_minute` and `lap_seconds` are tied to 0. The FSM and counters behave identically.

## Test plan
- Reset/run, TICKS_PER_SEC=4: deassert `reset`, pulse `start` at edge 0 → `seconds`=1 after edge 4, `seconds`=2 after edge 8, `state`=01.
- Rollover, TICKS_PER_SEC=1, MIN_WIDTH=2: run 60 cycles → `seconds`=0, `minute`=1. Run 240 cycles total → `minute` wraps to 0.
- Pause/resume, TICKS_PER_SEC=4: start, `stop` after 2 RUNNING cycles, hold PAUSED 10 cycles (no change), `start` → `seconds`=1 exactly 2 RUNNING cycles later.
- Priority: `start`+`stop`+`clear` together in RUNNING → IDLE, counts 0. `start`+`stop` in IDLE → RUNNING. Same pair in RUNNING → PAUSED.
- Lap FIFO, LAP_DEPTH=4: push 5 laps at distinct times → `lap_count`=4, `lap_overflow`=1, pops return the first 4 values in order. Push and pop together when full → `lap_count` stays 4. `clear` → `lap_overflow`=0, `lap_valid`=0.
- Async reset mid-run: drop `reset` between edges while `minute`=3 and the FIFO holds 2 entries → all outputs 0 immediately, with no clock edge needed.
